flog_front_ctrl: RTL and testbench

- Upstream control stage for the bfloat16 log2 datapath.
- Accepts packed bfloat16 operands on a valid/ready handshake and classifies each one.
- Special operands (zero, denormal, negative, inf, NaN, exactly 1.0) are resolved locally. Normal operands are issued to the log2 core, and the block waits for the core's result.
- Returns the packed result on a valid/ready output handshake, with a watchdog against a hung core.

---
 rtl/flog_front_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_flog_front_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flog_front_ctrl.sv
// Front-end controller for the bfloat16 log2 datapath: classifies operands, resolves specials locally,
// issues normals to the log2 core with a watchdog. Optional FLOG_STATS_EN adds accept counters.
module flog_front_ctrl #(
  parameter int EXP            = 8,
  parameter int MAN            = 7,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP+MAN:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP+MAN:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_timeout,
  output logic                 core_sign,
  output logic [EXP-1:0]       core_exponent,
  output logic [MAN-1:0]       core_fractional,
  output logic                 core_valid,
  input  logic                 core_s,
  input  logic [EXP-1:0]       core_e,
  input  logic [MAN-1:0]       core_f,
  input  logic                 core_done,
  output logic [1:0]           dbg_state
`ifdef FLOG_STATS_EN
  ,
  output logic [15:0]          stat_special,
  output logic [15:0]          stat_core
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // a producer holds valid and its data stable until that edge.

  localparam int W = 1 + EXP + MAN;

  localparam logic [W-1:0] C_NEG_INF = {1'b1, {EXP{1'b1}}, {MAN{1'b0}}};
  localparam logic [W-1:0] C_POS_INF = {1'b0, {EXP{1'b1}}, {MAN{1'b0}}};
  localparam logic [W-1:0] C_QNAN    = {1'b0, {EXP{1'b1}}, 1'b1, {(MAN-1){1'b0}}};
  localparam logic [W-1:0] C_ONE     = {1'b0, 1'b0, {(EXP-1){1'b1}}, {MAN{1'b0}}};
  localparam logic [W-1:0] C_ZERO    = '0;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_out_data;
  logic               r_out_valid;
  logic               r_err_timeout;
  logic               r_core_sign;
  logic [EXP-1:0]     r_core_exponent;
  logic [MAN-1:0]     r_core_fractional;
  logic               r_core_valid;
  logic [CNT_W-1:0]   r_wd;

  logic               w_sign;
  logic [EXP-1:0]     w_exp;
  logic [MAN-1:0]     w_frac;
  logic               w_special;
  logic [W-1:0]       w_special_res;
  logic               w_in_ready;
  logic               w_accept;

  assign w_sign = in_data[W-1];
  assign w_exp  = in_data[EXP+MAN-1:MAN];
  assign w_frac = in_data[MAN-1:0];

  // Order matters: zero/denormal first so -0 gives -inf, NaN before sign so -NaN stays NaN.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = C_ZERO;
    if (w_exp == '0) begin
      w_special_res = C_NEG_INF;
    end else if ((w_exp == {EXP{1'b1}}) && (w_frac != '0)) begin
      w_special_res = C_QNAN;
    end else if (w_sign) begin
      w_special_res = C_QNAN;
    end else if (w_exp == {EXP{1'b1}}) begin
      w_special_res = C_POS_INF;
    end else if (in_data == C_ONE) begin
      w_special_res = C_ZERO;
    end else begin
      w_special     = 1'b0;
    end
  end

  assign w_in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_out_data        <= '0;
      r_out_valid       <= 1'b0;
      r_err_timeout     <= 1'b0;
      r_core_sign       <= 1'b0;
      r_core_exponent   <= '0;
      r_core_fractional <= '0;
      r_core_valid      <= 1'b0;
      r_wd              <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_special) begin
              r_out_data    <= w_special_res;
              r_err_timeout <= 1'b0;
              r_out_valid   <= 1'b1;
              r_state       <= S_OUT;
            end else begin
              r_core_sign       <= w_sign;
              r_core_exponent   <= w_exp;
              r_core_fractional <= w_frac;
              r_core_valid      <= 1'b1;
              r_state           <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_core_valid <= 1'b0;
          r_wd         <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_wd <= r_wd + 1'b1;
          // A result arriving on the last watchdog cycle is still taken.
          if (core_done) begin
            r_out_data    <= {core_s, core_e, core_f};
            r_err_timeout <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= S_OUT;
          end else if (r_wd == WD_LAST) begin
            r_out_data    <= C_QNAN;
            r_err_timeout <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FLOG_STATS_EN
  logic [15:0] r_stat_special;
  logic [15:0] r_stat_core;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_special <= '0;
      r_stat_core    <= '0;
    end else if (w_accept) begin
      if (w_special) begin
        if (r_stat_special != 16'hFFFF) r_stat_special <= r_stat_special + 16'd1;
      end else begin
        if (r_stat_core != 16'hFFFF) r_stat_core <= r_stat_core + 16'd1;
      end
    end
  end

  assign stat_special = r_stat_special;
  assign stat_core    = r_stat_core;
`endif

  assign in_ready        = w_in_ready;
  assign out_data        = r_out_data;
  assign out_valid       = r_out_valid;
  assign err_timeout     = r_err_timeout;
  assign core_sign       = r_core_sign;
  assign core_exponent   = r_core_exponent;
  assign core_fractional = r_core_fractional;
  assign core_valid      = r_core_valid;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_flog_front_ctrl.sv
// Directed plus randomized bench for flog_front_ctrl with a behavioural log2 front-end model
// and a bench-side core model that answers after a chosen latency.
module tb_flog_front_ctrl;

  localparam int EXP            = 8;
  localparam int MAN            = 7;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CNT_W          = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_timeout;
  logic        core_sign;
  logic [7:0]  core_exponent;
  logic [6:0]  core_fractional;
  logic        core_valid;
  logic        core_s;
  logic [7:0]  core_e;
  logic [6:0]  core_f;
  logic        core_done;
  logic [1:0]  dbg_state;
`ifdef FLOG_STATS_EN
  logic [15:0] stat_special;
  logic [15:0] stat_core;
`endif

  int checks = 0;
  int errors = 0;
  int n_special = 0;
  int n_core = 0;
  logic [15:0] exp_q[$];

  logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h0001, 16'h807F, 16'hBF80, 16'h7F80,
                                 16'hFF80, 16'h7F81, 16'hFFC0, 16'h3F80, 16'hC0A0, 16'h8001};

  flog_front_ctrl #(
    .EXP(EXP), .MAN(MAN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_timeout(err_timeout), .core_sign(core_sign), .core_exponent(core_exponent),
    .core_fractional(core_fractional), .core_valid(core_valid), .core_s(core_s),
    .core_e(core_e), .core_f(core_f), .core_done(core_done), .dbg_state(dbg_state)
`ifdef FLOG_STATS_EN
    , .stat_special(stat_special), .stat_core(stat_core)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Returns {needs_core, local_result}: log2 of zero is -inf, of negatives/NaN a quiet NaN,
  // of +inf is +inf, of 1.0 is 0; anything else is a positive normal handled by the core.
  function automatic logic [16:0] ref_model(input logic [15:0] x);
    logic       is_neg   = x[15];
    logic [7:0] biased_e = x[14:7];
    logic [6:0] mant     = x[6:0];
    if (biased_e == 8'd0)                     return {1'b0, 16'hFF80};
    if (biased_e == 8'd255 && mant != 7'd0)   return {1'b0, 16'h7FC0};
    if (is_neg)                               return {1'b0, 16'h7FC0};
    if (biased_e == 8'd255)                   return {1'b0, 16'h7F80};
    if (x == 16'h3F80)                        return {1'b0, 16'h0000};
    return {1'b1, 16'h0000};
  endfunction

  // driver: called at a negedge; returns at a negedge after the output handshake
  task automatic do_op(input logic [15:0] x, input int lat, input logic [15:0] res,
                       input int bp, input logic [15:0] next_x);
    logic [16:0] m;
    logic [15:0] want;
    m = ref_model(x);
    check("in_ready_idle", in_ready, 1);
    in_data  = x;
    in_valid = 1'b1;
    exp_q.push_back(m[16] ? res : m[15:0]);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check("in_ready_busy", in_ready, 0);
    if (m[16]) begin
      n_core++;
      check("core_valid_pulse", core_valid, 1);
      check("core_sign", core_sign, x[15]);
      check("core_exponent", core_exponent, x[14:7]);
      check("core_fractional", core_fractional, x[6:0]);
      check("out_valid_issue", out_valid, 0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        check("core_valid_once", core_valid, 0);
        check("out_valid_early", out_valid, 0);
      end
      core_done = 1'b1;
      {core_s, core_e, core_f} = res;
      @(negedge clk);
      core_done = 1'b0;
      {core_s, core_e, core_f} = 16'($urandom);
    end else begin
      n_special++;
      check("core_valid_special", core_valid, 0);
    end
    want = exp_q.pop_front();
    check("out_valid", out_valid, 1);
    check("out_data", out_data, want);
    check("err_timeout", err_timeout, 0);
    for (int i = 0; i < bp; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = next_x;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, want);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  task automatic do_timeout(input logic [15:0] x);
    int n;
    check("to_in_ready", in_ready, 1);
    in_data  = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_core++;
    check("to_core_valid", core_valid, 1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    // the pulse cycle itself, then TIMEOUT_CYCLES cycles of waiting
    check("to_latency", n, TIMEOUT_CYCLES + 1);
    check("to_out_data", out_data, 16'h7FC0);
    check("to_err", err_timeout, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("to_out_drop", out_valid, 0);
  endtask

  initial begin
    logic [15:0] x;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    core_s = 1'b0; core_e = '0; core_f = '0; core_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_err", err_timeout, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_ops", {core_sign, core_exponent, core_fractional}, 16'h0000);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // directed: 2.0 through the core, specials, backpressure, done-vs-timeout tie, timeout
    do_op(16'h4000, 12, 16'h3F80, 0, 16'h0);
    for (int i = 0; i < 10; i++) do_op(specials[i], 1, 16'h0, 0, 16'h0);
    do_op(16'h4100, 3, 16'h1234, 5, 16'h0000);
    do_op(16'h0000, 1, 16'h0, 0, 16'h0);
    do_op(16'h4049, TIMEOUT_CYCLES, 16'h3FD5, 0, 16'h0);
    do_timeout(16'h4200);
    do_op(16'h7F7F, 1, 16'h42FE, 2, 16'h3F80);
    do_op(16'h3F80, 1, 16'h0, 0, 16'h0);

    // randomized
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) x = specials[$urandom_range(0, 11)];
      else x = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
      do_op(x, $urandom_range(1, 30), 16'($urandom), $urandom_range(0, 4), 16'($urandom));
    end

`ifdef FLOG_STATS_EN
    check("stat_special", stat_special, n_special);
    check("stat_core", stat_core, n_core);
`endif

    // reset while waiting on the core, then a stale core_done
    in_data  = 16'h4000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_core_valid", core_valid, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 16'h0000);
    check("mid_err", err_timeout, 0);
    check("mid_core_valid_rst", core_valid, 0);
    check("mid_core_ops", {core_sign, core_exponent, core_fractional}, 16'h0000);
    check("mid_state", dbg_state, 0);
    check("mid_in_ready", in_ready, 1);
`ifdef FLOG_STATS_EN
    check("mid_stat_special", stat_special, 0);
    check("mid_stat_core", stat_core, 0);
`endif
    @(negedge clk);
    core_done = 1'b1;
    {core_s, core_e, core_f} = 16'h4321;
    @(negedge clk);
    core_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("late_done_out_valid", out_valid, 0);
      check("late_done_in_ready", in_ready, 1);
      @(negedge clk);
    end
    do_op(16'h0001, 1, 16'h0, 0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
